pipe_hazard_ctrl: RTL

- Pipeline control unit for the 5-stage Y86-64 pipeline (F, D, E, M, W).
- Generates per-stage stall and bubble controls for load/use, mispredicted-jump and ret hazards, gates condition-code update, and stops the pipeline on exceptions.
- Runs an execution FSM (IDLE/RUN/HALTED/FAULT/TIMEOUT) with a watchdog and saturating performance counters.
- Sits beside the decode/write-back stage and drives the enables of all pipeline registers.

---
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Control unit for a 5-stage Y86-64 pipeline (F, D, E, M, W).
//   It detects load/use, mispredicted-jump and ret hazards, gates the
//   condition-code update, and freezes the pipeline on exceptions. An
//   execution FSM (IDLE/RUN/HALTED/FAULT/TIMEOUT) with a watchdog decides
//   when the pipeline may advance. Saturating counters record activity.
//
// Ports
//   clk, rst_n       : clock and synchronous active-low reset
//   start            : leave IDLE and begin execution
//   D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd, M_icode,
//   m_stat, W_stat, W_icode : pipeline status used for hazard detection
//   F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc :
//                      pipeline register controls (combinational in RUN)
//   state            : FSM state (IDLE=0 RUN=1 HALTED=2 FAULT=3 TIMEOUT=4)
//   final_stat       : W_stat captured on leaving RUN (0 on timeout)
//   cycle_cnt .. ret_bub_cnt : saturating performance counters
module pipe_hazard_ctrl #(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] MAX_CYCLES = 32'd100000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       D_icode,
    input  logic [3:0]       d_srcA,
    input  logic [3:0]       d_srcB,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_dstM,
    input  logic             e_Cnd,
    input  logic [3:0]       M_icode,
    input  logic [3:0]       m_stat,
    input  logic [3:0]       W_stat,
    input  logic [3:0]       W_icode,
    output logic             F_stall,
    output logic             D_stall,
    output logic             D_bubble,
    output logic             E_bubble,
    output logic             M_bubble,
    output logic             W_stall,
    output logic             set_cc,
    output logic [2:0]       state,
    output logic [3:0]       final_stat,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] lu_stall_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ret_bub_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_HALTED  = 3'd2,
        S_FAULT   = 3'd3,
        S_TIMEOUT = 3'd4
    } state_t;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_POPQ  = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam logic [3:0] S_AOK = 4'h1;
    localparam logic [3:0] S_HLT = 4'h2;
    localparam logic [3:0] S_ADR = 4'h3;
    localparam logic [3:0] S_INS = 4'h4;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t st;
    logic   lu, mis, rt, mex, wex, run, retire, wd_hit;

    assign state = st;

    // Hazard terms
    assign lu  = ((E_icode == I_MRMOV) || (E_icode == I_POPQ)) && (E_dstM != R_NONE) &&
                 ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign mis = (E_icode == I_JXX) && !e_Cnd;
    assign rt  = (D_icode == I_RET) || (E_icode == I_RET) || (M_icode == I_RET);
    assign mex = (m_stat == S_HLT) || (m_stat == S_ADR) || (m_stat == S_INS);
    assign wex = (W_stat == S_HLT) || (W_stat == S_ADR) || (W_stat == S_INS);

    // rst_n is folded in combinationally so the freeze shows while reset is held,
    // even before the first reset edge has cleared the state register.
    assign run = rst_n && (st == S_RUN);

    assign retire = (W_icode != I_HALT) && (W_icode != I_NOP) && (W_stat == S_AOK) && !wex;
    assign wd_hit = (MAX_CYCLES != 32'd0) && (cycle_cnt == CNT_W'(MAX_CYCLES - 32'd1));

    always_comb begin
        F_stall  = 1'b1;
        D_stall  = 1'b1;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_bubble = 1'b0;
        W_stall  = 1'b1;
        set_cc   = 1'b0;
        if (run) begin
            F_stall  = lu | rt;
            D_stall  = lu;
            // lu wins over rt so D is never stalled and bubbled together
            D_bubble = mis | (!lu & rt);
            E_bubble = mis | lu;
            M_bubble = mex | wex;
            W_stall  = wex;
            set_cc   = (E_icode == I_OPQ) & !mex & !wex;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + ONE : v;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st           <= S_IDLE;
            final_stat   <= 4'h0;
            cycle_cnt    <= '0;
            retire_cnt   <= '0;
            lu_stall_cnt <= '0;
            mispred_cnt  <= '0;
            ret_bub_cnt  <= '0;
        end else begin
            case (st)
                S_IDLE: if (start) st <= S_RUN;
                S_RUN: begin
                    cycle_cnt    <= sat_inc(cycle_cnt, 1'b1);
                    retire_cnt   <= sat_inc(retire_cnt, retire);
                    lu_stall_cnt <= sat_inc(lu_stall_cnt, lu);
                    mispred_cnt  <= sat_inc(mispred_cnt, mis);
                    ret_bub_cnt  <= sat_inc(ret_bub_cnt, !lu & rt);
                    // exceptions outrank the watchdog
                    if (W_stat == S_HLT) begin
                        st         <= S_HALTED;
                        final_stat <= W_stat;
                    end else if ((W_stat == S_ADR) || (W_stat == S_INS)) begin
                        st         <= S_FAULT;
                        final_stat <= W_stat;
                    end else if (wd_hit) begin
                        st         <= S_TIMEOUT;
                        final_stat <= 4'h0;
                    end
                end
                default: st <= st;  // terminal states wait for reset
            endcase
        end
    end

endmodule
